// File: rtl/if_stage_fetch_if.sv
// Instruction-memory bus and IF/ID payload between the fetch stage and its consumers.
// master: the fetch stage. slave: instruction memory and the ID stage.
interface if_stage_fetch_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_inst_o;
  logic        if_id_valid_o;

  modport master (
    output imem_addr_o,
    input  imem_inst_i,
    output if_id_pc_o,
    output if_id_inst_o,
    output if_id_valid_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_inst_i,
    input  if_id_pc_o,
    input  if_id_inst_o,
    input  if_id_valid_o
  );
endinterface

// File: rtl/if_stage_fetch.sv
// RV32 instruction-fetch stage with PC register and IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/flush/stall event counters.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        pc_sel_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  if_stage_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;
  logic            run_c;
  logic            redirect_c;
  logic            stall_hold_c;
  logic            load_valid_c;

  // Next state and register updates; the action follows the state being entered so
  // the first edge with start_i high already fetches.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_id_d      = if_id_q;
    redirect_c   = 1'b0;
    stall_hold_c = 1'b0;
    load_valid_c = 1'b0;

    case (state_q)
      IDLE:    if (start_i)  state_d = RUN;
      RUN:     if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    run_c = (state_d == RUN);

    if (run_c) begin
      if (pc_sel_i || flush_i) begin
        redirect_c = 1'b1;
        pc_d       = pc_sel_i ? {branch_target_i[XLEN-1:2], 2'b00} : pc_q + XLEN'(4);
        if_id_d.pc = pc_q;
        if (flush_i) begin
          if_id_d.inst  = NOP_INST;
          if_id_d.valid = 1'b0;
        end else begin
          if_id_d.inst  = bus.imem_inst_i;
          if_id_d.valid = 1'b1;
          load_valid_c  = 1'b1;
        end
      end else if (stall_i) begin
        stall_hold_c = 1'b1;
      end else begin
        pc_d          = pc_q + XLEN'(4);
        if_id_d.pc    = pc_q;
        if_id_d.inst  = bus.imem_inst_i;
        if_id_d.valid = 1'b1;
        load_valid_c  = 1'b1;
      end
    end else begin
      if_id_d.pc    = pc_q;
      if_id_d.inst  = NOP_INST;
      if_id_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      if_id_q.pc    <= '0;
      if_id_q.inst  <= NOP_INST;
      if_id_q.valid <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign pc_o              = pc_q;
  assign bus.imem_addr_o   = pc_q;
  assign bus.if_id_pc_o    = if_id_q.pc;
  assign bus.if_id_inst_o  = if_id_q.inst;
  assign bus.if_id_valid_o = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q, stall_cnt_q;
  logic        flush_ev_c;

  assign flush_ev_c = run_c && flush_i;

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load_valid_c && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (flush_ev_c   && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (stall_hold_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_c;
  assign unused_c = redirect_c ^ stall_hold_c ^ load_valid_c;
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch; instruction memory returns word index (mem[i] = i).
module tb_if_stage_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        flush;
  logic        pc_sel;
  logic [31:0] target;
  logic [31:0] pc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  if_stage_fetch_if bus ();

  assign bus.imem_inst_i = {2'b00, bus.imem_addr_o[31:2]};

  if_stage_fetch dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .flush_i         (flush),
    .pc_sel_i        (pc_sel),
    .branch_target_i (target),
    .pc_o            (pc),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_ipc, input logic [31:0] e_inst,
                             input logic e_valid);
    check({tag, ".pc"},       pc,                  e_pc);
    check({tag, ".imem"},     bus.imem_addr_o,     e_pc);
    check({tag, ".if_pc"},    bus.if_id_pc_o,      e_ipc);
    check({tag, ".if_inst"},  bus.if_id_inst_o,    e_inst);
    check({tag, ".if_valid"}, 32'(bus.if_id_valid_o), 32'(e_valid));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; pc_sel = 1'b0; target = '0;
    tick();
    check_state("reset", 32'h0, 32'h0, 32'h13, 1'b0);

    // Sequential fetch from reset
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state($sformatf("adv%0d", i), 32'(4 * (i + 1)), 32'(4 * i), 32'(i), 1'b1);
    end
    tick();
    check_state("adv3", 32'h10, 32'hC, 32'h3, 1'b1);

    // Load-use stall holds everything for two edges
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_state($sformatf("stall%0d", i), 32'h10, 32'hC, 32'h3, 1'b1);
    end
    stall = 1'b0;
    tick();
    check_state("resume", 32'h14, 32'h10, 32'h4, 1'b1);

    tick(); tick(); tick();
    check_state("at20", 32'h20, 32'h1C, 32'h7, 1'b1);

    // Taken branch: flush + target with low bits masked
    flush = 1'b1; pc_sel = 1'b1; target = 32'h103;
    tick();
    check_state("flush", 32'h100, 32'h20, 32'h13, 1'b0);
    flush = 1'b0; pc_sel = 1'b0;
    tick();
    check_state("post_flush", 32'h104, 32'h100, 32'h40, 1'b1);

    // Redirect outranks a simultaneous stall
    flush = 1'b1; pc_sel = 1'b1; stall = 1'b1; target = 32'h200;
    tick();
    check_state("redir_stall", 32'h200, 32'h104, 32'h13, 1'b0);

    // pc_sel without flush keeps the fetched instruction
    flush = 1'b0; stall = 1'b0; target = 32'hFFFF_FFFE;
    tick();
    check_state("sel_only", 32'hFFFF_FFFC, 32'h200, 32'h80, 1'b1);

    // PC wraps modulo 2^32
    pc_sel = 1'b0;
    tick();
    check_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 1'b1);

    // Idle: PC frozen, bubbles, redirect ignored
    start = 1'b0; flush = 1'b1; pc_sel = 1'b1; target = 32'h400; stall = 1'b1;
    tick();
    check_state("idle0", 32'h0, 32'h0, 32'h13, 1'b0);
    tick();
    check_state("idle1", 32'h0, 32'h0, 32'h13, 1'b0);
    flush = 1'b0; pc_sel = 1'b0; stall = 1'b0;

    // Flush-only redirect: PC+4 and a bubble
    start = 1'b1;
    tick(); tick();
    check_state("rerun", 32'h8, 32'h4, 32'h1, 1'b1);
    flush = 1'b1;
    tick();
    check_state("flush_only", 32'hC, 32'h8, 32'h13, 1'b0);
    flush = 1'b0;

    // Reset mid-run
    tick();
    rst = 1'b0;
    tick();
    check_state("mid_reset", 32'h0, 32'h0, 32'h13, 1'b0);

    // Reset released with start low: nothing moves
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_state("idle_after_reset", 32'h0, 32'h0, 32'h13, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
